external_device_buffer: RTL and testbench

Upstream producer for the cycle-stealing DMA engine. Collects a stream of 16-bit words from a device-side source into a 3-block × 4-word buffer. When the buffer is full, it raises a one-cycle interrupt to the CPU so the CPU can issue the DMA command. It then serves each 64-bit block on `edata`, selected by the DMA's `offset`, until the DMA signals completion, and then reopens for the next fill.

---
 rtl/external_device_buffer_pkg.sv | 26 ++
 rtl/external_device_buffer_if.sv | 31 +++
 rtl/external_device_buffer_block_buffer.sv | 44 ++++
 rtl/external_device_buffer.sv | 142 ++++++++++++++
 tb/tb_external_device_buffer.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/external_device_buffer_pkg.sv
// Shared definitions for the external device buffer and the DMA engine that
// drains it: word/block geometry, offset width and the buffer state encoding.
package external_device_buffer_pkg;

  localparam int WORD_SIZE       = 16;
  localparam int BLOCKS          = 3;
  localparam int WORDS_PER_BLOCK = 4;
  localparam int OFFSET_W        = 2;

  localparam int TOTAL_WORDS = BLOCKS * WORDS_PER_BLOCK;
  localparam int PTR_W       = $clog2(TOTAL_WORDS);
  localparam int BLOCK_W     = WORDS_PER_BLOCK * WORD_SIZE;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    DELAY  = 2'd1,
    NOTIFY = 2'd2,
    WAIT   = 2'd3
  } state_e;

  // offset values at or beyond BLOCKS do not address a block
  function automatic logic offset_legal(input logic [OFFSET_W-1:0] off);
    return off < OFFSET_W'(BLOCKS);
  endfunction

endpackage

// File: rtl/external_device_buffer_if.sv
// Handshake/bus bundle between the device-side source, the DMA/CPU side and
// the buffer.
//   in_valid/in_ready/in_data : device word stream into the buffer
//   bg/offset/dma_end         : DMA bus grant, block index, completion
//   edata                     : selected 64-bit block back to the DMA
//   dev_interrupt/incomplete  : CPU notification and sticky error flag
// master = environment (source, DMA, CPU); slave = the buffer.
interface external_device_buffer_if;
  import external_device_buffer_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [WORD_SIZE-1:0] in_data;
  logic                 bg;
  logic [OFFSET_W-1:0]  offset;
  logic                 dma_end;
  logic [BLOCK_W-1:0]   edata;
  logic                 dev_interrupt;
  logic                 incomplete;

  modport master (
    output in_valid, in_data, bg, offset, dma_end,
    input  in_ready, edata, dev_interrupt, incomplete
  );

  modport slave (
    input  in_valid, in_data, bg, offset, dma_end,
    output in_ready, edata, dev_interrupt, incomplete
  );

endinterface

// File: rtl/external_device_buffer_block_buffer.sv
// Word-write / block-read register array holding one full transfer.
//   clk     : clock
//   wr_en   : write in_data at wr_addr this edge
//   wr_addr : linear word index 0..TOTAL_WORDS-1 (block b owns 4b..4b+3)
//   wr_data : word to store
//   rd_blk  : block index, combinational read
//   rd_data : block rd_blk, word k at bits [16k+15:16k]; zero if rd_blk is
//             not a valid block
// Contents are not reset; they are always rewritten before being served.
module external_device_buffer_block_buffer
  import external_device_buffer_pkg::*;
(
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [PTR_W-1:0]     wr_addr,
  input  logic [WORD_SIZE-1:0] wr_data,
  input  logic [OFFSET_W-1:0]  rd_blk,
  output logic [BLOCK_W-1:0]   rd_data
);

  logic [BLOCK_W-1:0] mem_q [BLOCKS];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < BLOCKS; b++) begin
        for (int w = 0; w < WORDS_PER_BLOCK; w++) begin
          if (wr_addr == PTR_W'(b * WORDS_PER_BLOCK + w)) begin
            mem_q[b][w*WORD_SIZE +: WORD_SIZE] <= wr_data;
          end
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int b = 0; b < BLOCKS; b++) begin
      if (rd_blk == OFFSET_W'(b)) begin
        rd_data = mem_q[b];
      end
    end
  end

endmodule

// File: rtl/external_device_buffer.sv
// External device buffer: fills 3 blocks x 4 words from the device stream,
// pulses dev_interrupt NOTIFY_DELAY+1 cycles after the last word, then serves
// blocks to the DMA by offset until dma_end, flagging a short transfer.
//   CLK     : clock, all state changes on posedge
//   reset_n : asynchronous active-low reset
//   bus     : slave side of external_device_buffer_if
//
// state  | meaning
// -------+-------------------------------------------------------------
// FILL   | in_ready=1, accepting words into wr_ptr
// DELAY  | buffer full, counting cnt down to the notification
// NOTIFY | dev_interrupt high for this single cycle, seen_mask cleared
// WAIT   | serving buf[offset] on edata until dma_end
module external_device_buffer
  import external_device_buffer_pkg::*;
#(
  parameter int NOTIFY_DELAY = 2
) (
  input logic                      CLK,
  input logic                      reset_n,
  external_device_buffer_if.slave  bus
);

  localparam int CNT_W = (NOTIFY_DELAY < 2) ? 1 : $clog2(NOTIFY_DELAY + 1);

  state_e            state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BLOCKS-1:0] seen_mask_q, seen_mask_d;
  logic              in_ready_q, in_ready_d;
  logic              dev_interrupt_q, dev_interrupt_d;
  logic              incomplete_q, incomplete_d;

  logic               wr_en;
  logic               grant_ok;
  logic [BLOCK_W-1:0] rd_data;

  assign grant_ok = (bus.bg == 1'b1) && offset_legal(bus.offset);

  external_device_buffer_block_buffer u_block_buffer (
    .clk     (CLK),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q),
    .wr_data (bus.in_data),
    .rd_blk  (bus.offset),
    .rd_data (rd_data)
  );

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    cnt_d        = cnt_q;
    seen_mask_d  = seen_mask_q;
    incomplete_d = incomplete_q;
    wr_en        = 1'b0;

    case (state_q)
      FILL: begin
        if (bus.in_valid) begin
          wr_en = 1'b1;
          if (wr_ptr_q == PTR_W'(TOTAL_WORDS - 1)) begin
            wr_ptr_d = '0;
            if (NOTIFY_DELAY == 0) begin
              state_d     = NOTIFY;
              seen_mask_d = '0;
            end else begin
              state_d = DELAY;
              cnt_d   = CNT_W'(NOTIFY_DELAY);
            end
          end else begin
            wr_ptr_d = wr_ptr_q + 1'b1;
          end
        end
      end

      DELAY: begin
        if (cnt_q == '0) begin
          state_d     = NOTIFY;
          seen_mask_d = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      NOTIFY: begin
        state_d = WAIT;
      end

      WAIT: begin
        // dma_end takes priority over any grant seen on the same edge
        if (bus.dma_end) begin
          state_d  = FILL;
          wr_ptr_d = '0;
          if (seen_mask_q != '1) begin
            incomplete_d = 1'b1;
          end
        end else if (grant_ok) begin
          for (int b = 0; b < BLOCKS; b++) begin
            if (bus.offset == OFFSET_W'(b)) begin
              seen_mask_d[b] = 1'b1;
            end
          end
        end
      end

      default: begin
        state_d = FILL;
      end
    endcase

    // outputs registered from the next state so they align with it
    in_ready_d      = (state_d == FILL);
    dev_interrupt_d = (state_d == NOTIFY);
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= FILL;
      wr_ptr_q        <= '0;
      cnt_q           <= '0;
      seen_mask_q     <= '0;
      in_ready_q      <= 1'b1;
      dev_interrupt_q <= 1'b0;
      incomplete_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      wr_ptr_q        <= wr_ptr_d;
      cnt_q           <= cnt_d;
      seen_mask_q     <= seen_mask_d;
      in_ready_q      <= in_ready_d;
      dev_interrupt_q <= dev_interrupt_d;
      incomplete_q    <= incomplete_d;
    end
  end

  // combinational block select so the DMA sees data in the grant cycle
  assign bus.edata         = (state_q == WAIT && grant_ok) ? rd_data : '0;
  assign bus.in_ready      = in_ready_q;
  assign bus.dev_interrupt = dev_interrupt_q;
  assign bus.incomplete    = incomplete_q;

endmodule

// File: tb/tb_external_device_buffer.sv
module tb_external_device_buffer;
  import external_device_buffer_pkg::*;

  localparam int ND = 2;

  logic CLK = 1'b0;
  logic reset_n = 1'b0;
  always #5 CLK = ~CLK;

  external_device_buffer_if bus ();

  external_device_buffer #(.NOTIFY_DELAY(ND)) dut (
    .CLK     (CLK),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int irq_count = 0;
  logic probe = 1'b0;

  // behavioural reference: word store, served-block set, sticky flag
  logic [15:0] model_mem [12];
  bit [2:0]    model_seen;
  bit          model_inc;

  logic [63:0] exp_edata [$];
  int          exp_irq [$];

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic logic [63:0] model_block(input int o);
    logic [63:0] r = '0;
    if (o >= 3) return '0;
    for (int w = 3; w >= 0; w--) r = (r << 16) | 64'(model_mem[4*o + w]);
    return r;
  endfunction

  // monitor: edata on every probed cycle, interrupt timing on every pulse
  always @(negedge CLK) begin
    if (probe) begin
      if (exp_edata.size() == 0) begin
        checks++; errors++;
        $display("FAIL edata_queue: got probe with empty queue expected entry");
      end else begin
        chk("edata", bus.edata, exp_edata.pop_front());
      end
    end
    if (bus.dev_interrupt === 1'b1) begin
      irq_count++;
      checks++;
      if (exp_irq.size() == 0) begin
        errors++;
        $display("FAIL irq_unexpected: got pulse at cycle %0d expected none", cyc);
      end else begin
        int e;
        e = exp_irq.pop_front();
        if (e != cyc) begin
          errors++;
          $display("FAIL irq_cycle: got cycle %0d expected %0d", cyc, e);
        end
      end
    end
  end

  task automatic fill(input bit rnd, input bit junk, input int end_at);
    logic [15:0] w;
    int c;
    bit rdy;
    c = 0;
    for (int i = 0; i < 12; i++) begin
      if (i == end_at) begin
        // dma_end and a grant during FILL must both be ignored
        bus.in_valid = 1'b0; bus.dma_end = 1'b1; bus.bg = 1'b1; bus.offset = 2'd0;
        probe = 1'b1; exp_edata.push_back('0);
        @(posedge CLK); #1;
        bus.dma_end = 1'b0; bus.bg = 1'b0; probe = 1'b0;
      end
      if (rnd && $urandom_range(0, 2) == 0) begin
        bus.in_valid = 1'b0;
        repeat ($urandom_range(1, 2)) @(posedge CLK);
        #1;
      end
      w = rnd ? 16'($urandom) : 16'(i + 1);
      bus.in_valid = 1'b1; bus.in_data = w; rdy = 1'b0;
      for (int t = 0; t < 50 && !rdy; t++) begin
        @(negedge CLK); c = cyc; rdy = bus.in_ready;
        @(posedge CLK); #1;
      end
      chk("in_ready_seen", 64'(rdy), 64'd1);
      model_mem[i] = w;
    end
    exp_irq.push_back(c + ND + 2);
    if (junk) begin
      bus.in_valid = 1'b1; bus.in_data = 16'hDEAD;
    end else begin
      bus.in_valid = 1'b0;
    end
    @(negedge CLK);
    chk("in_ready_full", 64'(bus.in_ready), 64'd0);
    @(posedge CLK); #1;
  endtask

  task automatic wait_irq();
    int start;
    bit seen;
    start = irq_count; seen = 1'b0;
    for (int t = 0; t < 30 && !seen; t++) begin
      @(posedge CLK); #1;
      if (irq_count > start) seen = 1'b1;
    end
    chk("irq_arrived", 64'(seen), 64'd1);
  endtask

  task automatic serve(input int o);
    bus.bg = 1'b1; bus.offset = 2'(o); probe = 1'b1;
    exp_edata.push_back(model_block(o));
    @(posedge CLK); #1;
    probe = 1'b0;
    if (o < 3) model_seen[o] = 1'b1;
  endtask

  task automatic steal(input int n);
    bus.bg = 1'b0; bus.offset = 2'bzz; probe = 1'b1;
    for (int k = 0; k < n; k++) begin
      exp_edata.push_back('0);
      @(posedge CLK); #1;
    end
    probe = 1'b0;
  endtask

  task automatic end_dma();
    bus.in_valid = 1'b0; bus.bg = 1'b0; bus.offset = 2'd0; bus.dma_end = 1'b1;
    @(posedge CLK); #1;
    bus.dma_end = 1'b0;
    if (model_seen != 3'b111) model_inc = 1'b1;
    model_seen = '0;
    @(negedge CLK);
    chk("in_ready_after_end", 64'(bus.in_ready), 64'd1);
    chk("incomplete", 64'(bus.incomplete), 64'(model_inc));
    @(posedge CLK); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0; bus.in_data = '0; bus.bg = 1'b1; bus.offset = 2'd0;
    bus.dma_end = 1'b0;
    model_seen = '0; model_inc = 1'b0;
    #12;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_irq", 64'(bus.dev_interrupt), 64'd0);
    chk("rst_incomplete", 64'(bus.incomplete), 64'd0);
    chk("rst_edata", bus.edata, 64'd0);
    bus.bg = 1'b0;
    @(negedge CLK); reset_n = 1'b1;
    @(posedge CLK); #1;

    // fill 1..12 with junk held after full, then serve all
    fill(1'b0, 1'b1, -1);
    wait_irq();
    serve(0); serve(1); serve(2);
    end_dma();

    // cycle steal
    fill(1'b1, 1'b0, -1);
    wait_irq();
    serve(0); steal(5); serve(1); serve(2);
    end_dma();

    // ignored dma_end in FILL, illegal offset in WAIT
    fill(1'b1, 1'b0, 5);
    wait_irq();
    serve(3); serve(0); serve(3); serve(1); serve(2);
    end_dma();

    // early end, flag must stick through a full clean transfer
    fill(1'b1, 1'b0, -1);
    wait_irq();
    serve(0); serve(1);
    end_dma();
    fill(1'b1, 1'b0, -1);
    wait_irq();
    serve(2); serve(0); serve(1);
    end_dma();

    // reset during DELAY
    fill(1'b1, 1'b0, -1);
    reset_n = 1'b0;
    exp_irq.delete();
    model_inc = 1'b0; model_seen = '0;
    #1;
    chk("midrst_irq", 64'(bus.dev_interrupt), 64'd0);
    chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("midrst_incomplete", 64'(bus.incomplete), 64'd0);
    @(negedge CLK); reset_n = 1'b1;
    @(posedge CLK); #1;
    fill(1'b1, 1'b0, -1);
    wait_irq();
    serve(1); serve(2); serve(0);
    end_dma();

    repeat (3) @(posedge CLK);
    #1;
    chk("irq_queue_empty", 64'(exp_irq.size()), 64'd0);
    chk("edata_queue_empty", 64'(exp_edata.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
